// File: rtl/beat_interval_tracker.sv
// Beat interval tracker: measures tick intervals between debounced beats,
// averages the recent history and latches the tempo from an external lookup.
module beat_interval_tracker #(
  parameter int unsigned MIN_INTERVAL = 23529,
  parameter int unsigned MAX_INTERVAL = 193548,
  parameter int unsigned AVG_LOG2     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tick_en,
  input  logic        beat_in,
  input  logic [7:0]  bpm_in,
  output logic [31:0] interval_out,
  output logic        interval_valid,
  output logic [7:0]  bpm_out,
  output logic        bpm_locked
);

  localparam int CW    = 18;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = CW + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;

  localparam logic [CW-1:0] MIN_C = CW'(MIN_INTERVAL);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_INTERVAL);
  localparam logic [FW-1:0] FULL  = FW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    CONVERT
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0][CW-1:0]  hist_q, hist_d, hist_sh;
  logic [FW-1:0]             fill_q, fill_d, fill_inc;
  logic                      beat_dly_q;
  logic [31:0]               ivl_q, ivl_d;
  logic [7:0]                bpm_q, bpm_d;
  logic                      locked_q, locked_d;
  logic [SUM_W-1:0]          sum;
  logic [CW-1:0]             avg;
  logic                      beat_edge;
  logic                      accept;
  logic                      timeout;

  assign beat_edge = beat_in & ~beat_dly_q;
  assign accept    = (state_q == MEASURE) && beat_edge && (cnt_q >= MIN_C);
  assign timeout   = (state_q == MEASURE) && (cnt_q >= MAX_C);
  assign fill_inc  = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

  // History as it will look once the current count is pushed in.
  always_comb begin
    hist_sh[0] = cnt_q;
    for (int i = 1; i < DEPTH; i++) begin
      hist_sh[i] = hist_q[i-1];
    end
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + SUM_W'(hist_sh[i]);
    end
  end

  assign avg = CW'(sum >> AVG_LOG2);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    ivl_d    = ivl_q;
    bpm_d    = bpm_q;
    locked_d = locked_q;
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hist_d   = '0;
      fill_d   = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
          cnt_d   = '0;
        end
        ARMED: begin
          if (beat_edge) begin
            cnt_d   = '0;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // An accepted beat wins over a coincident timeout.
          if (accept) begin
            hist_d  = hist_sh;
            fill_d  = fill_inc;
            cnt_d   = '0;
            ivl_d   = (fill_inc == FULL) ? 32'(avg) : 32'(cnt_q);
            state_d = CONVERT;
          end else if (timeout) begin
            hist_d   = '0;
            fill_d   = '0;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = ARMED;
          end else if (tick_en) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CONVERT: begin
          bpm_d    = bpm_in;
          locked_d = (fill_q == FULL);
          state_d  = MEASURE;
          if (tick_en) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hist_q     <= '0;
      fill_q     <= '0;
      beat_dly_q <= 1'b0;
      ivl_q      <= '0;
      bpm_q      <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      beat_dly_q <= beat_in;
      ivl_q      <= ivl_d;
      bpm_q      <= bpm_d;
      locked_q   <= locked_d;
    end
  end

  assign interval_out   = ivl_q;
  assign interval_valid = (state_q == CONVERT);
  assign bpm_out        = bpm_q;
  assign bpm_locked     = locked_q;

endmodule

// File: tb/tb_beat_interval_tracker.sv
// Bench for beat_interval_tracker: directed scenarios then random beats,
// all checked cycle by cycle against an event-level reference model.
module tb_beat_interval_tracker;

  localparam int MIN_I = 40;
  localparam int MAX_I = 300;
  localparam int LOG2  = 2;
  localparam int DEPTH = 4;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_MEAS  = 2;
  localparam int P_CONV  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tick_en = 1'b0;
  logic        beat_in = 1'b0;
  logic [7:0]  bpm_in;
  logic [31:0] interval_out;
  logic        interval_valid;
  logic [7:0]  bpm_out;
  logic        bpm_locked;

  always #5 clk = ~clk;

  beat_interval_tracker #(
    .MIN_INTERVAL(MIN_I),
    .MAX_INTERVAL(MAX_I),
    .AVG_LOG2(LOG2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .tick_en(tick_en),
    .beat_in(beat_in),
    .bpm_in(bpm_in),
    .interval_out(interval_out),
    .interval_valid(interval_valid),
    .bpm_out(bpm_out),
    .bpm_locked(bpm_locked)
  );

  // External tempo lookup: beats per minute for a 400 Hz-scaled timebase.
  function automatic int lookup(input logic [31:0] iv);
    int q;
    if (iv == 0) return 255;
    q = 24000 / int'(iv);
    return (q > 255) ? 255 : q;
  endfunction

  always_comb bpm_in = 8'(lookup(interval_out));

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  int m_phase;
  int m_ticks;
  int m_hist[$];
  int m_iv;
  int m_bpm;
  bit m_locked;
  bit m_prev;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = P_IDLE;
    m_ticks = 0;
    m_hist.delete();
    m_iv = 0;
    m_bpm = 0;
    m_locked = 0;
    m_prev = 0;
  endtask

  task automatic model(input bit e, input bit t, input bit b);
    bit rise;
    int s;
    rise = b && !m_prev;
    m_prev = b;
    if (!e) begin
      m_phase = P_IDLE;
      m_ticks = 0;
      m_hist.delete();
      m_locked = 0;
    end else if (m_phase == P_IDLE) begin
      m_phase = P_ARMED;
      m_ticks = 0;
    end else if (m_phase == P_ARMED) begin
      if (rise) begin
        m_ticks = 0;
        m_phase = P_MEAS;
      end
    end else if (m_phase == P_MEAS) begin
      if (rise && m_ticks >= MIN_I) begin
        m_hist.push_back(m_ticks);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        if (m_hist.size() < DEPTH) m_iv = m_ticks;
        else begin
          s = 0;
          foreach (m_hist[i]) s += m_hist[i];
          m_iv = s / DEPTH;
        end
        m_ticks = 0;
        m_phase = P_CONV;
      end else if (m_ticks >= MAX_I) begin
        m_hist.delete();
        m_locked = 0;
        m_ticks = 0;
        m_phase = P_ARMED;
      end else if (t) begin
        m_ticks++;
      end
    end else begin
      m_bpm = lookup(32'(m_iv));
      m_locked = (m_hist.size() == DEPTH);
      m_phase = P_MEAS;
      if (t) m_ticks++;
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(interval_valid), 32'(m_phase == P_CONV));
    chk("interval", interval_out, 32'(m_iv));
    chk("bpm", 32'(bpm_out), 32'(m_bpm));
    chk("locked", 32'(bpm_locked), 32'(m_locked));
    if (interval_valid) n_valid++;
  endtask

  task automatic step(input bit e, input bit t, input bit b);
    @(negedge clk);
    enable = e;
    tick_en = t;
    beat_in = b;
    model(e, t, b);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic pulse();
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_iv", interval_out, 32'd0);
    chk("rst_valid", 32'(interval_valid), 32'd0);
    chk("rst_bpm", 32'(bpm_out), 32'd0);
    chk("rst_lock", 32'(bpm_locked), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    #3;
    chk("por_iv", interval_out, 32'd0);
    chk("por_valid", 32'(interval_valid), 32'd0);
    chk("por_bpm", 32'(bpm_out), 32'd0);
    chk("por_lock", 32'(bpm_locked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Steady tempo: six beats 200 ticks apart.
    step(1'b1, 1'b0, 1'b0);
    n_valid = 0;
    pulse();
    repeat (5) begin
      gap(200);
      pulse();
    end
    gap(1);
    chk("steady_pulses", 32'(n_valid), 32'd5);
    chk("steady_bpm", 32'(bpm_out), 32'd120);
    chk("steady_lock", 32'(bpm_locked), 32'd1);
    gap(199);

    // Bounce at 20 ticks is ignored, counting continues.
    pulse();
    gap(20);
    pulse();
    chk("bounce_valid", 32'(interval_valid), 32'd0);
    gap(179);
    pulse();
    chk("debounce_iv", interval_out, 32'd200);

    // MIN-1 rejected, exactly MIN accepted.
    gap(39);
    pulse();
    chk("min_m1_valid", 32'(interval_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    pulse();
    chk("min_valid", 32'(interval_valid), 32'd1);
    chk("min_avg_iv", interval_out, 32'd160);

    // Timeout with no beats.
    gap(400);
    chk("to_lock", 32'(bpm_locked), 32'd0);
    chk("to_bpm", 32'(bpm_out), 32'd150);
    pulse();
    gap(200);
    pulse();
    chk("to_next_iv", interval_out, 32'd200);
    gap(1);
    chk("to_next_lock", 32'(bpm_locked), 32'd0);
    chk("to_next_bpm", 32'(bpm_out), 32'd120);

    // Averaging 160,160,240,240.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    pulse();
    gap(160); pulse();
    gap(160); pulse();
    gap(240); pulse();
    gap(240); pulse();
    chk("avg_iv", interval_out, 32'd200);
    gap(1);
    chk("avg_lock", 32'(bpm_locked), 32'd1);

    // Beat coincident with counter at MAX: beat wins.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    pulse();
    gap(300);
    pulse();
    chk("tie_valid", 32'(interval_valid), 32'd1);
    chk("tie_iv", interval_out, 32'd300);

    // Enable drop in MEASURE, then in CONVERT.
    gap(50);
    step(1'b0, 1'b1, 1'b0);
    chk("drop_meas_bpm", 32'(bpm_out), 32'd80);
    step(1'b1, 1'b1, 1'b0);
    gap(50);
    pulse();
    gap(100);
    pulse();
    chk("drop_pre_valid", 32'(interval_valid), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("drop_conv_valid", 32'(interval_valid), 32'd0);
    chk("drop_conv_bpm", 32'(bpm_out), 32'd80);
    chk("drop_conv_lock", 32'(bpm_locked), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    pulse();
    gap(60);
    pulse();
    chk("reen_iv", interval_out, 32'd60);

    // Reset in the middle of a measurement.
    gap(30);
    async_reset();
    step(1'b1, 1'b0, 1'b0);

    // Random beats, tick gaps, enable drops and resets.
    for (int k = 0; k < 150; k++) begin
      int r;
      int g;
      int w;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        async_reset();
      end else if (r < 9) begin
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b1, 1'b0);
      end else begin
        g = $urandom_range(0, 360);
        w = $urandom_range(1, 3);
        for (int c = 0; c < g; c++)
          step(1'b1, $urandom_range(0, 3) != 0, 1'b0);
        for (int c = 0; c < w; c++)
          step(1'b1, $urandom_range(0, 3) != 0, 1'b1);
      end
    end
    gap(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
